// File: rtl/mem_refill_ctrl.sv
// Backing memory plus line-refill sequencer for the read-only cache.
// A request is accepted in IDLE. After LATENCY edges the whole line is
// streamed one beat per cycle, starting at the requested (critical) offset
// and wrapping inside the line. A preload write port fills the array while
// the block is idle.
module mem_refill_ctrl #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 8,
  parameter int OFFSET_W = 2,
  parameter int LATENCY  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  input  logic [ADDR_W-1:0]   req_addr,
  output logic                req_ready,
  output logic                fill_valid,
  output logic [DATA_W-1:0]   fill_data,
  output logic [OFFSET_W-1:0] fill_offset,
  output logic                fill_last,
  output logic                busy,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data
);

  localparam int BEATS = 2 ** OFFSET_W;
  localparam int CNT_W = 4;   // LATENCY is at most 15

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

  state_t              r_state, w_next;
  logic [CNT_W-1:0]    r_lat_cnt;
  logic [OFFSET_W-1:0] r_beat;
  logic [OFFSET_W-1:0] r_start;
  logic [ADDR_W-1:0]   r_base;
  logic [DATA_W-1:0]   r_mem [0:(2**ADDR_W)-1];

  logic                w_accept;
  logic                w_emit;
  logic                w_emit_last;
  logic [OFFSET_W-1:0] w_beat_off;
  logic [ADDR_W-1:0]   w_rd_addr;

  assign w_accept   = req_valid && (r_state == S_IDLE);
  // Offset arithmetic is OFFSET_W wide, so the wrap stays inside the line.
  assign w_beat_off = r_start + r_beat;
  assign w_rd_addr  = r_base | {{(ADDR_W-OFFSET_W){1'b0}}, w_beat_off};
  // Beat 0 leaves on the edge where the latency counter expires; later
  // beats follow back to back until the last one has been presented.
  assign w_emit      = ((r_state == S_WAIT) && (r_lat_cnt == CNT_W'(1))) ||
                       ((r_state == S_BURST) && !fill_last);
  assign w_emit_last = w_emit && (r_beat == OFFSET_W'(BEATS - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_WAIT;
      S_WAIT:  if (r_lat_cnt == CNT_W'(1)) w_next = S_BURST;
      S_BURST: if (fill_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request capture, counters and registered beat outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lat_cnt   <= '0;
      r_beat      <= '0;
      r_start     <= '0;
      r_base      <= '0;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      fill_valid  <= 1'b0;
      fill_last   <= 1'b0;
      fill_data   <= '0;
      fill_offset <= '0;
    end else begin
      // Handshake flags track the state being entered so they are flops.
      req_ready  <= (w_next == S_IDLE);
      busy       <= (w_next != S_IDLE);
      fill_valid <= w_emit;
      fill_last  <= w_emit_last;
      if (w_accept) begin
        r_base    <= {req_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
        r_start   <= req_addr[OFFSET_W-1:0];
        r_lat_cnt <= CNT_W'(LATENCY);
        r_beat    <= '0;
      end else if (r_state == S_WAIT) begin
        r_lat_cnt <= r_lat_cnt - CNT_W'(1);
      end
      // fill_data/fill_offset hold their last value between beats.
      if (w_emit) begin
        fill_data   <= r_mem[w_rd_addr];
        fill_offset <= w_beat_off;
        r_beat      <= r_beat + OFFSET_W'(1);
      end
    end
  end

  // Preload port; writes outside IDLE are dropped. Storage is not reset.
  always_ff @(posedge clk) begin
    if (wr_en && (r_state == S_IDLE)) r_mem[wr_addr] <= wr_data;
  end

endmodule

// File: tb/tb_mem_refill_ctrl.sv
// Bench for mem_refill_ctrl: a LATENCY=4 and a LATENCY=1 instance share
// stimulus; sel picks which one a request goes to. A byte-array model and
// line arithmetic give the expected beats.
module tb_mem_refill_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic sel, wr_both;
  logic req_valid, wr_en;
  logic [10:0] req_addr, wr_addr;
  logic [7:0]  wr_data;

  logic r4, v4, l4, b4, r1, v1, l1, b1;
  logic [7:0] d4, d1;
  logic [1:0] o4, o1;
  logic o_ready, o_valid, o_last, o_busy;
  logic [7:0] o_data;
  logic [1:0] o_off;

  int checks = 0;
  int errors = 0;
  logic [7:0] mdl [0:2047];
  logic [3:0][7:0] got;

  always #5 clk = ~clk;

  mem_refill_ctrl #(.LATENCY(4)) u_d4 (
    .clk(clk), .reset(reset), .req_valid(req_valid && !sel), .req_addr(req_addr),
    .req_ready(r4), .fill_valid(v4), .fill_data(d4), .fill_offset(o4),
    .fill_last(l4), .busy(b4), .wr_en(wr_en && (wr_both || !sel)),
    .wr_addr(wr_addr), .wr_data(wr_data));

  mem_refill_ctrl #(.LATENCY(1)) u_d1 (
    .clk(clk), .reset(reset), .req_valid(req_valid && sel), .req_addr(req_addr),
    .req_ready(r1), .fill_valid(v1), .fill_data(d1), .fill_offset(o1),
    .fill_last(l1), .busy(b1), .wr_en(wr_en && (wr_both || sel)),
    .wr_addr(wr_addr), .wr_data(wr_data));

  assign o_ready = sel ? r1 : r4;
  assign o_valid = sel ? v1 : v4;
  assign o_last  = sel ? l1 : l4;
  assign o_busy  = sel ? b1 : b4;
  assign o_data  = sel ? d1 : d4;
  assign o_off   = sel ? o1 : o4;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [10:0] a, input logic [7:0] d);
    wr_both = 1'b1; wr_en = 1'b1; wr_addr = a; wr_data = d;
    mdl[a] = d;
    @(negedge clk);
    wr_en = 1'b0; wr_both = 1'b0;
  endtask

  // Entered and left at a falling edge. Requests line fill of a on the
  // selected instance and checks every cycle of the transaction.
  task automatic fill_check(input logic [10:0] a, input int abort_at,
                            input bit hold, input logic [10:0] hold_addr,
                            input bit coll, input logic [7:0] cdata,
                            input bit drop_wr,
                            output logic [3:0][7:0] g);
    int lat, n, off, ea;
    lat = sel ? 1 : 4;
    g = '0;
    req_addr = a; req_valid = 1'b1;
    if (coll) begin wr_both = 1'b1; wr_en = 1'b1; wr_addr = a; wr_data = cdata; end
    n = 0;
    while (!o_ready && n < 50) begin @(negedge clk); n++; end
    if (!o_ready) begin
      chk("accept_timeout", 0, 1);
      req_valid = 1'b0; wr_en = 1'b0; wr_both = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (coll) begin wr_en = 1'b0; wr_both = 1'b0; mdl[a] = cdata; end
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      chk("wait_valid", {31'd0, o_valid}, 0);
      chk("wait_busy_ready", {30'd0, o_busy, o_ready}, 32'b10);
      if (hold && k == 0) begin req_valid = 1'b1; req_addr = hold_addr; end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      off = (int'(a) % 4 + i) % 4;
      ea  = (int'(a) / 4) * 4 + off;
      g[i] = o_data;
      chk("beat_valid_busy_ready", {29'd0, o_valid, o_busy, o_ready}, 32'b110);
      chk("beat_offset", {30'd0, o_off}, off);
      chk("beat_data", {24'd0, o_data}, {24'd0, mdl[ea]});
      chk("beat_last", {31'd0, o_last}, (i == 3) ? 1 : 0);
      if (i == abort_at) begin
        reset = 1'b1;
        #1;
        chk("abort_outputs", {29'd0, o_valid, o_last, o_busy}, 0);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (drop_wr && i == 1) begin
        wr_addr = a + 11'd1; wr_data = ~mdl[a + 11'd1]; wr_en = 1'b1;
      end else begin
        wr_en = 1'b0;
      end
    end
    @(negedge clk);
    wr_en = 1'b0;
    chk("end_valid_last", {30'd0, o_valid, o_last}, 0);
    chk("end_ready_busy", {30'd0, o_ready, o_busy}, 32'b10);
  endtask

  typedef struct {
    logic [10:0]     addr;
    bit              sel;
    bit              hold;
    logic [10:0]     hold_addr;
    logic [3:0][7:0] exp;
  } vec_t;

  vec_t tbl [5];

  initial begin
    tbl[0] = '{11'h009, 1'b0, 1'b1, 11'h020, {8'hA0, 8'hA3, 8'hA2, 8'hA1}};
    tbl[1] = '{11'h020, 1'b0, 1'b0, 11'h000, {8'h23, 8'h22, 8'h21, 8'h20}};
    tbl[2] = '{11'h7FF, 1'b0, 1'b0, 11'h000, {8'h12, 8'h11, 8'h10, 8'h13}};
    tbl[3] = '{11'h00A, 1'b1, 1'b0, 11'h000, {8'hA1, 8'hA0, 8'hA3, 8'hA2}};
    tbl[4] = '{11'h7FC, 1'b1, 1'b0, 11'h000, {8'h13, 8'h12, 8'h11, 8'h10}};

    sel = 1'b0; wr_both = 1'b0; req_valid = 1'b0; wr_en = 1'b0;
    req_addr = '0; wr_addr = '0; wr_data = '0;
    reset = 1'b1;
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("reset_outputs", {o_valid, o_last, o_busy, o_off, o_data}, 0);
    end
    sel = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_ready4", {31'd0, r4}, 1);
    chk("post_reset_ready1", {31'd0, r1}, 1);

    for (int i = 0; i < 4; i++) begin
      preload(11'h008 + 11'(i), 8'hA0 + 8'(i));
      preload(11'h020 + 11'(i), 8'h20 + 8'(i));
      preload(11'h7FC + 11'(i), 8'h10 + 8'(i));
      preload(11'h004 + 11'(i), 8'h40 + 8'(i));
      preload(11'h010 + 11'(i), 8'h60 + 8'(i));
    end

    // Critical word / busy rejection / top of space / LATENCY=1.
    for (int r = 0; r < 5; r++) begin
      sel = tbl[r].sel;
      fill_check(tbl[r].addr, -1, tbl[r].hold, tbl[r].hold_addr, 1'b0, 8'h00, 1'b0, got);
      chk($sformatf("tbl%0d_data", r), got, tbl[r].exp);
    end

    // Write/request collision, then dropped write during burst.
    sel = 1'b0;
    fill_check(11'h005, -1, 1'b0, 11'h0, 1'b1, 8'h5A, 1'b1, got);
    chk("coll_first_beat", {24'd0, got[0]}, 32'h5A);
    fill_check(11'h006, -1, 1'b0, 11'h0, 1'b0, 8'h00, 1'b0, got);
    chk("dropped_write_old", {24'd0, got[0]}, 32'h42);

    // Reset during beat 2, then a full fill from retained memory.
    fill_check(11'h010, 2, 1'b0, 11'h0, 1'b0, 8'h00, 1'b0, got);
    fill_check(11'h021, -1, 1'b0, 11'h0, 1'b0, 8'h00, 1'b0, got);
    chk("after_reset_fill", got, {8'h20, 8'h23, 8'h22, 8'h21});

    // Random lines, offsets, instances, collisions and dropped writes.
    for (int t = 0; t < 30; t++) begin
      logic [10:0] base, a;
      base = 11'($urandom_range(0, 511) * 4);
      for (int i = 0; i < 4; i++) preload(base + 11'(i), 8'($urandom));
      sel = 1'($urandom);
      a = base + 11'($urandom_range(0, 3));
      fill_check(a, -1, 1'b0, 11'h0, ($urandom % 4) == 0, 8'($urandom),
                 ($urandom % 3) == 0, got);
      fill_check(base + 11'($urandom_range(0, 3)), -1, 1'b0, 11'h0, 1'b0, 8'h00, 1'b0, got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
